// File: rtl/text_console_writer_if.sv
// Byte-stream handshake into the text console writer.
// The master offers bytes and the slave accepts them with ready.
interface text_console_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;

  modport master (output in_valid, output in_char, input in_ready);
  modport slave  (input in_valid, input in_char, output in_ready);
endinterface

// File: rtl/text_console_writer.sv
// Turns a byte stream into single-cycle cell writes on the text VRAM write port.
// It keeps a cursor and handles CR/LF/BS/FF, clearing a row on every row advance and the page on FF.
module text_console_writer #(
  parameter int         COLS         = 50,
  parameter int         ROWS         = 15,
  parameter logic [7:0] BLANK_CHAR   = 8'h20,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  text_console_writer_if.slave  in_if,
  input  logic                  attr_we,
  input  logic [7:0]            attr_in,
  output logic                  ram_ce,
  output logic [11:0]           ram_addr,
  output logic [15:0]           ram_data,
  output logic [5:0]            cur_col,
  output logic [3:0]            cur_row,
  output logic                  busy
);

  localparam logic [11:0] COLS_A        = 12'(COLS);
  localparam logic [5:0]  LAST_COL      = 6'(COLS - 1);
  localparam logic [3:0]  LAST_ROW      = 4'(ROWS - 1);
  localparam logic [11:0] LAST_CELL     = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LAST_ROW_CELL = 12'(COLS - 1);

  if (COLS < 1 || COLS > 64 || ROWS < 1 || ROWS > 16 || COLS * ROWS > 4096) begin : g_bad_geometry
    $error("text_console_writer: COLS x ROWS does not fit the 6-bit column, 4-bit row and 12-bit address");
  end

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;
  typedef enum logic [2:0] {K_PRINT, K_LF, K_CR, K_BS, K_FF, K_IGNORE} kind_t;

  function automatic kind_t classify(input logic [7:0] ch);
    if (ch == 8'h0A)                     return K_LF;
    else if (ch == 8'h0D)                return K_CR;
    else if (ch == 8'h08)                return K_BS;
    else if (ch == 8'h0C)                return K_FF;
    else if (ch < 8'h20 || ch == 8'h7F)  return K_IGNORE;
    else                                 return K_PRINT;
  endfunction

  function automatic logic [11:0] row_base(input logic [3:0] r);
    return 12'(r) * COLS_A;
  endfunction

  state_t      state, state_next;
  logic [11:0] clr_cnt, clr_cnt_next;
  logic [11:0] clr_base, clr_base_next;
  logic [7:0]  clr_attr, clr_attr_next;
  logic [7:0]  attr;
  logic [5:0]  col, col_next;
  logic [3:0]  row, row_next;
  logic [3:0]  row_adv;
  logic [11:0] cell_addr;
  logic        advance;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  kind_t       kind;

  assign kind      = classify(in_if.in_char);
  assign row_adv   = (row == LAST_ROW) ? 4'd0 : row + 4'd1;
  assign cell_addr = row_base(row) + 12'(col);
  assign cur_col   = col;
  assign cur_row   = row;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    clr_cnt_next  = clr_cnt;
    clr_base_next = clr_base;
    clr_attr_next = clr_attr;
    col_next      = col;
    row_next      = row;
    advance       = 1'b0;
    case (state)
      CLEAR_ALL, CLEAR_ROW: begin
        clr_cnt_next = clr_cnt + 12'd1;
        if (clr_cnt == ((state == CLEAR_ALL) ? LAST_CELL : LAST_ROW_CELL)) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end
      end
      IDLE: begin
        if (in_if.in_valid) begin
          case (kind)
            K_PRINT: begin
              if (col == LAST_COL) begin
                col_next = '0;
                advance  = 1'b1;
              end else begin
                col_next = col + 6'd1;
              end
            end
            K_LF: begin
              col_next = '0;
              advance  = 1'b1;
            end
            K_CR: col_next = '0;
            K_BS: if (col != '0) col_next = col - 6'd1;
            K_FF: begin
              col_next      = '0;
              row_next      = '0;
              state_next    = CLEAR_ALL;
              clr_cnt_next  = '0;
              clr_base_next = '0;
              clr_attr_next = attr;
            end
            default: ;
          endcase
          // Scroll-by-overwrite: the destination row is blanked before more text lands in it.
          if (advance) begin
            row_next      = row_adv;
            state_next    = CLEAR_ROW;
            clr_cnt_next  = '0;
            clr_base_next = row_base(row_adv);
            clr_attr_next = attr;
          end
        end
      end
      default: state_next = CLEAR_ALL;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ram_addr;
    wr_data = ram_data;
    case (state)
      CLEAR_ALL, CLEAR_ROW: begin
        wr_en   = 1'b1;
        wr_addr = clr_base + clr_cnt;
        wr_data = {clr_attr, BLANK_CHAR};
      end
      IDLE: begin
        if (in_if.in_valid) begin
          if (kind == K_PRINT) begin
            wr_en   = 1'b1;
            wr_addr = cell_addr;
            wr_data = {attr, in_if.in_char};
          end else if (kind == K_BS && col != '0) begin
            wr_en   = 1'b1;
            wr_addr = cell_addr - 12'd1;
            wr_data = {attr, BLANK_CHAR};
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: registers use <= so every flop samples the same pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= CLEAR_ALL;
      clr_cnt        <= '0;
      clr_base       <= '0;
      clr_attr       <= DEFAULT_ATTR;
      attr           <= DEFAULT_ATTR;
      col            <= '0;
      row            <= '0;
      ram_ce         <= 1'b0;
      ram_addr       <= '0;
      ram_data       <= '0;
      in_if.in_ready <= 1'b0;
      busy           <= 1'b1;
    end else begin
      state          <= state_next;
      clr_cnt        <= clr_cnt_next;
      clr_base       <= clr_base_next;
      clr_attr       <= clr_attr_next;
      col            <= col_next;
      row            <= row_next;
      ram_ce         <= wr_en;
      ram_addr       <= wr_addr;
      ram_data       <= wr_data;
      in_if.in_ready <= (state_next == IDLE);
      busy           <= (state_next != IDLE);
      // A byte accepted this cycle already captured the old attribute above.
      if (attr_we) attr <= attr_in;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: directed cases plus random byte streams
// compared against a cursor/VRAM-write reference model.
module tb_text_console_writer;
  localparam int COLS  = 50;
  localparam int ROWS  = 15;
  localparam int CELLS = COLS * ROWS;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        attr_we = 1'b0;
  logic [7:0]  attr_in = 8'h00;
  logic        ram_ce;
  logic [11:0] ram_addr;
  logic [15:0] ram_data;
  logic [5:0]  cur_col;
  logic [3:0]  cur_row;
  logic        busy;

  text_console_writer_if bus();

  text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .in_if    (bus),
    .attr_we  (attr_we),
    .attr_in  (attr_in),
    .ram_ce   (ram_ce),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  initial forever #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int          cyc = 0;
  logic [27:0] obs_q[$];
  int          obs_cyc[$];
  logic [27:0] exp_q[$];

  int         mcol;
  int         mrow;
  logic [7:0] mattr;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (ram_ce === 1'b1) begin
      obs_q.push_back({ram_addr, ram_data});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_write(input int addr, input logic [7:0] a, input logic [7:0] g);
    exp_q.push_back({12'(addr), a, g});
  endtask

  task automatic push_blank_row(input int r);
    for (int c = 0; c < COLS; c++) push_write(r * COLS + c, mattr, 8'h20);
  endtask

  // Reference behaviour: cursor movement and the ordered list of VRAM writes a byte causes.
  task automatic model_byte(input logic [7:0] ch, output bit clears);
    clears = 1'b0;
    if (ch == 8'h0C) begin
      mcol = 0;
      mrow = 0;
      for (int i = 0; i < CELLS; i++) push_write(i, mattr, 8'h20);
      clears = 1'b1;
    end else if (ch == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
      push_blank_row(mrow);
      clears = 1'b1;
    end else if (ch == 8'h0D) begin
      mcol = 0;
    end else if (ch == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        push_write(mrow * COLS + mcol, mattr, 8'h20);
      end
    end else if (ch < 8'h20 || ch == 8'h7F) begin
      clears = 1'b0;
    end else begin
      push_write(mrow * COLS + mcol, mattr, ch);
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        push_blank_row(mrow);
        clears = 1'b1;
      end
    end
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (bus.in_ready !== 1'b1) check({tag, "_timeout"}, int'(bus.in_ready), 1);
  endtask

  task automatic send_byte(input logic [7:0] ch, input bit do_attr, input logic [7:0] new_attr);
    bit clears;
    wait_ready(2000, "send_wait");
    bus.in_valid = 1'b1;
    bus.in_char  = ch;
    attr_we      = do_attr;
    attr_in      = new_attr;
    step();
    bus.in_valid = 1'b0;
    attr_we      = 1'b0;
    model_byte(ch, clears);
    if (do_attr) mattr = new_attr;
    check("ready_after_accept", int'(bus.in_ready), clears ? 0 : 1);
  endtask

  task automatic settle(input bit allow_attr);
    step();
    if (allow_attr && $urandom_range(0, 3) == 0) begin
      attr_we = 1'b1;
      attr_in = 8'($urandom);
      step();
      attr_we = 1'b0;
      mattr   = attr_in;
    end
    wait_ready(2000, "settle");
    step();
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_write"}, int'(obs_q[i]), int'(exp_q[i]));
      if (obs_q[i] != exp_q[i]) break;
    end
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, int'(cur_col), mcol);
    check({tag, "_row"}, int'(cur_row), mrow);
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    if (r < 40) return 8'($urandom_range(32'h20, 32'h7E));
    if (r < 70) return 8'($urandom_range(32'h80, 32'hFF));
    if (r < 78) return 8'h0A;
    if (r < 84) return 8'h0D;
    if (r < 92) return 8'h08;
    if (r < 94) return 8'h0C;
    case ($urandom_range(0, 4))
      0:       return 8'h00;
      1:       return 8'h07;
      2:       return 8'h1B;
      3:       return 8'h7F;
      default: return 8'h0B;
    endcase
  endfunction

  task automatic send_n_print(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(32'h21, 32'h7E)), 1'b0, 8'h00);
  endtask

  task automatic send_n_lf(input int n);
    for (int i = 0; i < n; i++) send_byte(8'h0A, 1'b0, 8'h00);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    mcol  = 0;
    mrow  = 0;
    mattr = 8'h0F;

    // Reset values
    reset = 1'b1;
    repeat (3) step();
    check("rst_ram_ce", int'(ram_ce), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_data", int'(ram_data), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_busy", int'(busy), 1);
    check_cursor("rst");
    obs_q.delete();
    obs_cyc.delete();

    // Power-up clear: 750 back-to-back blank writes with the default attribute
    for (int i = 0; i < CELLS; i++) push_write(i, 8'h0F, 8'h20);
    reset = 1'b0;
    wait_ready(2000, "init_clear");
    step();
    if (obs_cyc.size() > 0) check("init_span", obs_cyc[$] - obs_cyc[0], CELLS - 1);
    compare_writes("init_clear");
    check("init_busy", int'(busy), 0);
    check_cursor("init");

    // Attribute load then 'A'
    attr_we = 1'b1;
    attr_in = 8'h1E;
    step();
    attr_we = 1'b0;
    mattr   = 8'h1E;
    send_byte(8'h41, 1'b0, 8'h00);
    check("A_ce", int'(ram_ce), 1);
    check("A_addr", int'(ram_addr), 0);
    check("A_data", int'(ram_data), 32'h1E41);
    settle(1'b0);
    compare_writes("A");
    check_cursor("A");

    // Fill a full row, then the wrap clears row 1
    send_byte(8'h0C, 1'b0, 8'h00);
    settle(1'b0);
    compare_writes("ff1");
    send_n_print(COLS);
    check("row_end_addr", int'(ram_addr), COLS - 1);
    check("row_end_col", int'(cur_col), 0);
    check("row_end_row", int'(cur_row), 1);
    settle(1'b0);
    compare_writes("row_fill");

    // LF from the last row wraps to row 0
    send_n_lf(ROWS - 2);
    send_n_print(5);
    settle(1'b0);
    compare_writes("to_5_14");
    check_cursor("at_5_14");
    send_byte(8'h0A, 1'b0, 8'h00);
    settle(1'b0);
    compare_writes("lf_wrap");
    check_cursor("lf_wrap");

    // CR moves without writing
    send_byte(8'h0C, 1'b0, 8'h00);
    send_n_lf(3);
    send_n_print(7);
    settle(1'b0);
    compare_writes("to_7_3");
    send_byte(8'h0D, 1'b0, 8'h00);
    settle(1'b0);
    compare_writes("cr");
    check_cursor("cr");

    // Backspace mid-row and at column 0
    send_byte(8'h0C, 1'b0, 8'h00);
    send_n_lf(2);
    send_n_print(3);
    settle(1'b0);
    compare_writes("to_3_2");
    send_byte(8'h08, 1'b0, 8'h00);
    check("bs_ce", int'(ram_ce), 1);
    check("bs_addr", int'(ram_addr), 102);
    check("bs_glyph", int'(ram_data[7:0]), 32'h20);
    settle(1'b0);
    compare_writes("bs");
    check_cursor("bs");
    send_byte(8'h0C, 1'b0, 8'h00);
    send_n_lf(2);
    settle(1'b0);
    compare_writes("to_0_2");
    send_byte(8'h08, 1'b0, 8'h00);
    settle(1'b0);
    compare_writes("bs_col0");
    check_cursor("bs_col0");

    // Random byte stream, attribute changes in the same cycle as bytes and during clears
    for (int i = 0; i < 300; i++) begin
      send_byte(rand_byte(), $urandom_range(0, 7) == 0, 8'($urandom));
      settle(1'b1);
      compare_writes("rand");
      check_cursor("rand");
    end

    // Reset in the middle of a page clear restarts the full clear
    send_byte(8'h0C, 1'b0, 8'h00);
    n = 0;
    while (!(ram_ce === 1'b1 && ram_addr == 12'd299) && n < 2000) begin
      step();
      n++;
    end
    check("mid_clear_reached", int'(ram_addr), 299);
    reset = 1'b1;
    step();
    check("mid_rst_ce_low", int'(ram_ce), 0);
    check("mid_rst_ready", int'(bus.in_ready), 0);
    reset = 1'b0;
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    mcol  = 0;
    mrow  = 0;
    mattr = 8'h0F;
    for (int i = 0; i < CELLS; i++) push_write(i, mattr, 8'h20);
    wait_ready(2000, "restart_clear");
    step();
    if (obs_cyc.size() > 0) check("restart_span", obs_cyc[$] - obs_cyc[0], CELLS - 1);
    compare_writes("restart_clear");
    check_cursor("restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
